// File: rtl/layer0_feature_packer.sv
// layer0_feature_packer
// Integrates a signed ADC readout trace over fixed windows, quantizes each
// window mean to a small unsigned code and packs NUM_FEAT codes into one
// vector for the layer-0 neuron tables. Single-entry output buffer with
// valid/ready handshakes on both sides.
module layer0_feature_packer #(
   parameter int SAMPLE_W = 16,
   parameter int WINDOW   = 8,
   parameter int NUM_FEAT = 16,
   parameter int FEAT_W   = 2,
   parameter int Q_SHIFT  = 12
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic [SAMPLE_W-1:0]          s_data,
   input  logic                         s_last,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [NUM_FEAT*FEAT_W-1:0]   m_data,
   output logic                         m_trunc
);

   localparam int LOG2W  = $clog2(WINDOW);
   localparam int ACC_W  = SAMPLE_W + LOG2W;
   localparam int SCNT_W = LOG2W;
   localparam int FCNT_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
   localparam int VEC_W  = NUM_FEAT * FEAT_W;

   localparam logic [FEAT_W-1:0]       MID_CODE = FEAT_W'(2 ** (FEAT_W - 1));
   localparam logic [VEC_W-1:0]        MID_VEC  = {NUM_FEAT{MID_CODE}};
   localparam logic signed [ACC_W-1:0] BIAS     = ACC_W'(2 ** (FEAT_W - 1));
   localparam logic signed [ACC_W-1:0] MAX_CODE = ACC_W'(2 ** FEAT_W - 1);

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t                     state_q, state_d;
   logic signed [ACC_W-1:0]    acc_q, acc_d;
   logic [SCNT_W-1:0]          sample_cnt_q, sample_cnt_d;
   logic [FCNT_W-1:0]          feat_cnt_q, feat_cnt_d;
   logic [VEC_W-1:0]           vec_q, vec_d;
   logic [VEC_W-1:0]           m_data_q, m_data_d;
   logic                       m_valid_q, m_valid_d;
   logic                       m_trunc_q, m_trunc_d;
   logic                       s_ready_q, s_ready_d;

   logic                       accept;
   logic signed [ACC_W-1:0]    sum;
   logic [FEAT_W-1:0]          code;
   logic                       win_done;
   logic                       last_slot;
   logic [VEC_W-1:0]           slot_vec;

   // Floor mean, coarse shift, bias to unsigned and saturate.
   function automatic logic [FEAT_W-1:0] quantize(input logic signed [ACC_W-1:0] total);
      logic signed [ACC_W-1:0] mean;
      logic signed [ACC_W-1:0] v;
      logic signed [ACC_W-1:0] biased;
      mean   = total >>> LOG2W;
      v      = mean >>> Q_SHIFT;
      biased = v + BIAS;
      if (biased < 0)
         return '0;
      else if (biased > MAX_CODE)
         return '1;
      else
         return biased[FEAT_W-1:0];
   endfunction

   assign s_ready = s_ready_q;
   assign m_valid = m_valid_q;
   assign m_data  = m_data_q;
   assign m_trunc = m_trunc_q;

   // Next-state: window accumulation, slot coding, vector close and output handshake.
   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      sample_cnt_d = sample_cnt_q;
      feat_cnt_d   = feat_cnt_q;
      vec_d        = vec_q;
      m_data_d     = m_data_q;
      m_valid_d    = m_valid_q;
      m_trunc_d    = m_trunc_q;

      accept    = s_valid && s_ready_q && (state_q == ACCUM);
      sum       = acc_q + {{LOG2W{s_data[SAMPLE_W-1]}}, s_data};
      code      = quantize(sum);
      win_done  = (sample_cnt_q == SCNT_W'(WINDOW - 1));
      last_slot = (feat_cnt_q == FCNT_W'(NUM_FEAT - 1));
      slot_vec  = vec_q;
      slot_vec[feat_cnt_q*FEAT_W +: FEAT_W] = code;

      case (state_q)
         ACCUM: begin
            if (accept) begin
               if ((win_done && last_slot) || s_last) begin
                  // Unfilled slots already hold the midpoint code, so an early
                  // close only needs the current (possibly partial) slot written.
                  m_data_d     = slot_vec;
                  m_valid_d    = 1'b1;
                  m_trunc_d    = !(win_done && last_slot);
                  acc_d        = '0;
                  sample_cnt_d = '0;
                  feat_cnt_d   = '0;
                  vec_d        = MID_VEC;
                  state_d      = HOLD;
               end else if (win_done) begin
                  vec_d        = slot_vec;
                  acc_d        = '0;
                  sample_cnt_d = '0;
                  feat_cnt_d   = feat_cnt_q + 1'b1;
               end else begin
                  acc_d        = sum;
                  sample_cnt_d = sample_cnt_q + 1'b1;
               end
            end
         end
         HOLD: begin
            if (m_ready) begin
               m_valid_d = 1'b0;
               state_d   = ACCUM;
            end
         end
         default: state_d = ACCUM;
      endcase

      s_ready_d = !m_valid_d;
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ACCUM;
         acc_q        <= '0;
         sample_cnt_q <= '0;
         feat_cnt_q   <= '0;
         vec_q        <= MID_VEC;
         m_data_q     <= '0;
         m_valid_q    <= 1'b0;
         m_trunc_q    <= 1'b0;
         s_ready_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         sample_cnt_q <= sample_cnt_d;
         feat_cnt_q   <= feat_cnt_d;
         vec_q        <= vec_d;
         m_data_q     <= m_data_d;
         m_valid_q    <= m_valid_d;
         m_trunc_q    <= m_trunc_d;
         s_ready_q    <= s_ready_d;
      end
   end

endmodule
